// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared types and constants for the boot/dump controller
// Purpose: FSM state enum, header field positions and word-to-byte shift.
// Ports: none (package).
package cpu_boot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  // Header fields: H0 = {N_I, N_D}, H2 = {N_O, B}
  localparam int FIELD_W   = 16;
  localparam int H0_NI_LSB = 16;
  localparam int H0_ND_LSB = 0;
  localparam int H2_NO_LSB = 16;
  localparam int H2_B_LSB  = 0;

  // Word index to byte address
  localparam int WORD_SHIFT = 2;

  // Destination tag carried with each registered stream word
  localparam logic [1:0] TAG_HDR  = 2'd0;
  localparam logic [1:0] TAG_IMEM = 2'd1;
  localparam logic [1:0] TAG_DMEM = 2'd2;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// rtl/cpu_boot_ctrl_if.sv - input word stream and dump stream bundle
// Purpose: groups the two valid/ready streams of the boot controller.
// Ports: s_valid/s_data/s_ready (boot words in), m_valid/m_data/m_ready (dump words out).
// master = environment side, slave = controller side.
interface cpu_boot_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/cpu_boot_ctrl_sink.sv
// rtl/cpu_boot_ctrl_sink.sv - stream accept-and-register stage for header and load phases
// Purpose: accepts words while enabled, counts them within a phase and presents a
// registered {valid, index, data, tag} one cycle after acceptance.
// Ports: clk, arst_n, en, clr, s_valid, s_data, tag (in);
//        s_ready, fire, k, w_valid, w_index, w_data, w_tag (out).
module stream_word_sink #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [1:0]        tag,
  output logic              s_ready,
  output logic              fire,
  output logic [CNT_W-1:0]  k,
  output logic              w_valid,
  output logic [CNT_W-1:0]  w_index,
  output logic [DATA_W-1:0] w_data,
  output logic [1:0]        w_tag
);
  assign s_ready = en;
  assign fire    = en & s_valid;

  // clr wins over an accept so the next phase always starts at index 0
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)    k <= '0;
    else if (clr)   k <= '0;
    else if (fire)  k <= k + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) w_valid <= 1'b0;
    else         w_valid <= fire;
  end

  reg_arstn_en #(.W(CNT_W))  u_idx  (.clk(clk), .arst_n(arst_n), .en(fire), .d(k),      .q(w_index));
  reg_arstn_en #(.W(DATA_W)) u_data (.clk(clk), .arst_n(arst_n), .en(fire), .d(s_data), .q(w_data));
  reg_arstn_en #(.W(2))      u_tag  (.clk(clk), .arst_n(arst_n), .en(fire), .d(tag),    .q(w_tag));
endmodule

// File: rtl/reg_arstn_en.sv
// rtl/reg_arstn_en.sv - enabled register with asynchronous active-low reset
// Purpose: generic W-bit storage element loaded when en is high.
// Ports: clk, arst_n, en, d (in); q (out).
module reg_arstn_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  q <= RST_VAL;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - boot loader, run timer and result dump for the pipelined cpu
// Purpose: loads imem/dmem from a header-framed word stream, enables the cpu for R
// cycles, then streams a window of dmem back out.
// Ports: clk, arst_n, start (in); bus (slave streams); cpu_enable (out);
//        addr_ext/wen_ext/wdata_ext (imem write port, out);
//        addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 (out), rdata_ext_2 (in) (dmem port);
//        busy, done (out).
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  cpu_boot_ctrl_if.slave    bus,
  output logic              cpu_enable,
  output logic [DATA_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [DATA_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);
  state_t state, state_nx;
  state_t after_hdr, after_i, after_d, after_run;

  logic [CNT_W-1:0]  n_i, n_d, n_o, b, j, n_o_eff, dump_idx, k, w_index;
  logic [31:0]       r, run_cnt;
  logic              fire, sink_en, sink_clr, w_valid, wr_pend;
  logic [DATA_W-1:0] w_data;
  logic [1:0]        tag, w_tag;

  assign sink_en  = (state == S_HDR0) || (state == S_HDR1) || (state == S_HDR2) ||
                    (state == S_LOAD_I) || (state == S_LOAD_D);
  assign tag      = (state == S_LOAD_I) ? TAG_IMEM : (state == S_LOAD_D) ? TAG_DMEM : TAG_HDR;
  assign sink_clr = (state_nx != state);

  stream_word_sink #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_sink (
    .clk(clk), .arst_n(arst_n), .en(sink_en), .clr(sink_clr),
    .s_valid(bus.s_valid), .s_data(bus.s_data), .tag(tag),
    .s_ready(bus.s_ready), .fire(fire), .k(k),
    .w_valid(w_valid), .w_index(w_index), .w_data(w_data), .w_tag(w_tag)
  );

  // SRAM write pulses trail acceptance by one cycle
  assign wen_ext   = w_valid && (w_tag == TAG_IMEM);
  assign wen_ext_2 = w_valid && (w_tag == TAG_DMEM);
  assign wr_pend   = wen_ext | wen_ext_2;
  assign addr_ext  = wen_ext ? (DATA_W'(w_index) << WORD_SHIFT) : '0;
  assign wdata_ext = wen_ext ? w_data : '0;
  assign wdata_ext_2 = wen_ext_2 ? w_data : '0;

  // The final load write may still be in flight when RUN/DUMP_RD is entered;
  // holding off one cycle keeps enable and reads clear of it.
  assign dump_idx   = b + j;
  assign ren_ext_2  = (state == S_DUMP_RD) && !wr_pend;
  assign addr_ext_2 = ren_ext_2 ? (DATA_W'(dump_idx) << WORD_SHIFT) :
                      wen_ext_2 ? (DATA_W'(w_index) << WORD_SHIFT) : '0;
  assign cpu_enable = (state == S_RUN) && !wr_pend;

  assign bus.m_valid = (state == S_DUMP_OUT);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

  // N_O arrives with H2, so the all-zero skip chain must look at it directly
  assign n_o_eff   = (state == S_HDR2) ? CNT_W'(bus.s_data[H2_NO_LSB +: FIELD_W]) : n_o;
  assign after_run = (n_o_eff != '0) ? S_DUMP_RD : S_DONE;
  assign after_d   = (r != 32'd0) ? S_RUN : after_run;
  assign after_i   = (n_d != '0) ? S_LOAD_D : after_d;
  assign after_hdr = (n_i != '0) ? S_LOAD_I : after_i;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_HDR0;
      S_HDR0:      if (fire) state_nx = S_HDR1;
      S_HDR1:      if (fire) state_nx = S_HDR2;
      S_HDR2:      if (fire) state_nx = after_hdr;
      S_LOAD_I:    if (fire && (k == n_i - CNT_W'(1))) state_nx = after_i;
      S_LOAD_D:    if (fire && (k == n_d - CNT_W'(1))) state_nx = after_d;
      S_RUN:       if (cpu_enable && (run_cnt == 32'd1)) state_nx = after_run;
      S_DUMP_RD:   if (ren_ext_2) state_nx = S_DUMP_WAIT;
      S_DUMP_WAIT: state_nx = S_DUMP_OUT;
      S_DUMP_OUT:  if (bus.m_ready) state_nx = (j == n_o - CNT_W'(1)) ? S_DONE : S_DUMP_RD;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= S_IDLE;
      n_i     <= '0;
      n_d     <= '0;
      n_o     <= '0;
      b       <= '0;
      j       <= '0;
      r       <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_HDR0 && fire) begin
        n_i <= CNT_W'(bus.s_data[H0_NI_LSB +: FIELD_W]);
        n_d <= CNT_W'(bus.s_data[H0_ND_LSB +: FIELD_W]);
      end
      if (state == S_HDR1 && fire) begin
        r       <= 32'(bus.s_data);
        run_cnt <= 32'(bus.s_data);
      end
      if (state == S_HDR2 && fire) begin
        n_o <= CNT_W'(bus.s_data[H2_NO_LSB +: FIELD_W]);
        b   <= CNT_W'(bus.s_data[H2_B_LSB +: FIELD_W]);
        j   <= '0;
      end
      if (cpu_enable) run_cnt <= run_cnt - 32'd1;
      if (state == S_DUMP_OUT && bus.m_ready) j <= j + CNT_W'(1);
    end
  end

  reg_arstn_en #(.W(DATA_W)) u_mdata (
    .clk(clk), .arst_n(arst_n), .en(state == S_DUMP_WAIT), .d(rdata_ext_2), .q(bus.m_data)
  );
endmodule

// File: doc/cpu_boot_ctrl.md
# cpu_boot_ctrl

Boot and result-dump controller placed directly upstream of the pipelined `cpu`. It accepts a word stream over a valid/ready handshake, writes the stream into instruction and data memory through the CPU's external SRAM ports, and holds the CPU `enable` high for a programmed number of cycles. It then reads a programmed window of data memory back out over a second valid/ready stream.

## Interface
Parameters:
- `DATA_W`, 32: stream, SRAM data and address width.
- `CNT_W`, 16: width of the word-count and index fields.

Ports:
- `clk`  in  1  main clock; single clock domain.
- `arst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a session; sampled only in IDLE.
- `s_valid`  in  1  input stream word valid.
- `s_data`  in  32  input stream word.
- `s_ready`  out  1  input stream ready.
- `m_valid`  out  1  dump stream word valid.
- `m_data`  out  32  dump stream word.
- `m_ready`  in  1  dump stream ready.
- `cpu_enable`  out  1  drives `cpu.enable`.
- `addr_ext`, `wen_ext`, `wdata_ext`  out  32/1/32  instruction-memory external write port.
- `addr_ext_2`, `wen_ext_2`, `ren_ext_2`, `wdata_ext_2`  out  32/1/1/32  data-memory external port.
- `rdata_ext_2`  in  32  data-memory external read data.
- `busy`  out  1  high from `start` acceptance until DONE.
- `done`  out  1  single-cycle pulse when the session ends.

## Operation
- Stream format, in this order:
  - H0 = {N_I[31:16], N_D[15:0]}
  - H1 = R, the 32-bit run-cycle count
  - H2 = {N_O[31:16], B[15:0]}, where N_O is the dump count and B is the dump base word index
  - N_I instruction words, then N_D data words.
- A word is accepted on a cycle where `s_valid & s_ready`.
- Word k of a load phase is written to byte address 4*k (k starts at 0 in each phase). Instruction words use the `_ext` port; data words use the `_ext_2` port.
- FSM states and transitions:
  - IDLE: leaves on `start` to HDR0.
  - HDR0 → HDR1 → HDR2 → LOAD_I → LOAD_D → RUN → DUMP_RD → DUMP_WAIT → DUMP_OUT → DONE → IDLE.
- Skip rules:
  - N_I=0 skips LOAD_I.
  - N_D=0 skips LOAD_D.
  - R=0 skips RUN.
  - N_O=0 goes straight to DONE.
- `s_ready` is high only in HDR0/1/2, LOAD_I and LOAD_D.
- RUN: `cpu_enable`=1 for exactly R consecutive cycles, driven by a 32-bit down-counter. `cpu_enable` is 0 in every other state.
- Dump of word j (0..N_O-1):
  - DUMP_RD issues `ren_ext_2`=1 with `addr_ext_2`=4*(B+j). The address sum is computed mod 2^16 and then zero-extended.
  - DUMP_WAIT captures `rdata_ext_2` into `m_data`.
  - DUMP_OUT holds `m_valid`=1 with `m_data` stable until `m_ready`. After the handshake the FSM goes to DUMP_RD for the next j, or to DONE after the last word.
- `start` outside IDLE is ignored. Stream words are not accepted outside the header and load states.
- Counters are CNT_W-bit. Index k never exceeds N-1, so no wrap occurs within a phase.

## Timing
- Reset value of every output is 0. This covers `s_ready`, `m_valid`, `m_data`, `cpu_enable`, all `addr`/`wen`/`ren`/`wdata` outputs, `busy` and `done`. The FSM resets to IDLE and all counters clear.
- Assertion of `arst_n` low mid-session aborts immediately. No partial write or enable cycle is issued after reset.
- SRAM writes are registered: a word accepted in cycle t produces a one-cycle `wen` pulse in cycle t+1 with matching `addr` and `wdata`.
- The first RUN cycle is no earlier than one cycle after the last write pulse. `cpu_enable` never overlaps any `wen_ext`/`wen_ext_2`.
- The SRAM external read returns data in the cycle after `ren_ext_2` is sampled. A dump word therefore takes at least 3 cycles.
- `busy` rises the cycle after `start` is accepted and falls in the cycle `done` pulses.
- If `s_valid` stalls, the FSM waits with no timeout and `s_ready` stays high.

## Structure
- Shared package `cpu_boot_pkg` holds:
  - the state enum;
  - field-position constants for H0 and H2;
  - the byte-per-word shift constant of 2.
- Natural sub-module: `stream_word_sink`, which performs the accept-and-register step for the header and load phases. It outputs a registered {valid, index, data}.
- Use the existing `reg_arstn_en` for the output registers where convenient.

## Test plan
- Full session:
  - Stream: H0=0x0003_0002, H1=5, H2=0x0002_0001, then 0xA, 0xB, 0xC, 0x11, 0x22.
  - Required: imem writes 0xA/0xB/0xC at addresses 0/4/8; dmem writes 0x11/0x22 at 0/4; `cpu_enable` high for exactly 5 cycles; dump reads address 4 then 8.
- Backpressure: hold `m_ready`=0 for 4 cycles in DUMP_OUT -> `m_valid` stays 1 and `m_data` is unchanged; exactly N_O words are emitted.
- Zero counts: H0=0, H1=0, H2=0 -> no `wen`, no `cpu_enable` and no `ren` occur; `done` pulses after HDR2 plus one cycle.
- Input stalls: deassert `s_valid` between every word -> the write sequence is identical to the stall-free case; no extra `wen` pulses occur.
- Reset mid-RUN with R=100: pull `arst_n` low after 10 enable cycles -> all outputs are 0 at once; after release the block stays in IDLE until `start`.
- Ignored `start`: pulse `start` during LOAD_I -> the session is unaffected and `busy` stays 1.
